// File: rtl/quad_stream_driver_if.sv
// quad_stream_driver_if: coefficient write port, three coefficient streams and the returned root stream
interface quad_stream_driver_if #(parameter int SIZE = 32);
  logic [3*SIZE-1:0] wr_data;
  logic wr_valid, wr_ready;
  logic [SIZE-1:0] m_axis_a_tdata, m_axis_b_tdata, m_axis_c_tdata;
  logic m_axis_a_tvalid, m_axis_b_tvalid, m_axis_c_tvalid;
  logic m_axis_a_tready, m_axis_b_tready, m_axis_c_tready;
  logic [SIZE-1:0] s_axis_result_tdata;
  logic s_axis_result_tvalid, s_axis_result_tready;
  logic [SIZE-1:0] res_data;
  logic res_valid;
  modport master(
    input wr_data, wr_valid, m_axis_a_tready, m_axis_b_tready, m_axis_c_tready,
    input s_axis_result_tdata, s_axis_result_tvalid,
    output wr_ready, m_axis_a_tdata, m_axis_b_tdata, m_axis_c_tdata,
    output m_axis_a_tvalid, m_axis_b_tvalid, m_axis_c_tvalid,
    output s_axis_result_tready, res_data, res_valid
  );
  modport slave(
    output wr_data, wr_valid, m_axis_a_tready, m_axis_b_tready, m_axis_c_tready,
    output s_axis_result_tdata, s_axis_result_tvalid,
    input wr_ready, m_axis_a_tdata, m_axis_b_tdata, m_axis_c_tdata,
    input m_axis_a_tvalid, m_axis_b_tvalid, m_axis_c_tvalid,
    input s_axis_result_tready, res_data, res_valid
  );
endinterface

// File: rtl/quad_stream_driver.sv
// quad_stream_driver: buffers coefficient triples and streams them out in batches, tracking returned roots
module quad_stream_driver #(
  parameter int SIZE = 32,
  parameter int DEPTH = 16,
  parameter int MAX_INFLIGHT = 128
) (
  input  logic aclk,
  input  logic areset,
  input  logic start,
  quad_stream_driver_if.master bus,
  output logic busy,
  output logic done,
  output logic err,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(MAX_INFLIGHT+1);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [3*SIZE-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr, count, batch;
  logic [2:0] acc, hs, tv;
  logic wr, pop, res_hs, room;
  assign count = wptr - rptr;
  assign room = inflight != IW'(MAX_INFLIGHT);
  assign tv = (state == ISSUE && batch != 0 && room) ? ~acc : 3'b000;
  assign {bus.m_axis_a_tvalid, bus.m_axis_b_tvalid, bus.m_axis_c_tvalid} = tv;
  assign {bus.m_axis_a_tdata, bus.m_axis_b_tdata, bus.m_axis_c_tdata} = mem[rptr[AW-1:0]];
  assign hs = tv & {bus.m_axis_a_tready, bus.m_axis_b_tready, bus.m_axis_c_tready};
  // a triple retires once every channel has handshaken, now or earlier
  assign pop = tv != 3'b000 && (acc | hs) == 3'b111;
  assign bus.wr_ready = state == IDLE && !count[AW] && !areset;
  assign wr = bus.wr_valid && bus.wr_ready;
  assign bus.s_axis_result_tready = !areset;
  assign res_hs = bus.s_axis_result_tvalid && bus.s_axis_result_tready;
  assign busy = state == ISSUE || state == DRAIN;
  assign done = state == DONE;
  always_ff @(posedge aclk)
    if (wr) mem[wptr[AW-1:0]] <= bus.wr_data;
  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= IDLE;
      wptr <= '0;
      rptr <= '0;
      acc <= '0;
      batch <= '0;
      inflight <= '0;
      err <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_data <= '0;
    end else begin
      wptr <= wptr + (AW+1)'(wr);
      rptr <= rptr + (AW+1)'(pop);
      acc <= pop ? 3'b000 : acc | hs;
      batch <= (state == IDLE && start && count != 0) ? count : batch - (AW+1)'(pop);
      inflight <= (pop && !res_hs) ? inflight + IW'(1) :
                  (res_hs && !pop && inflight != 0) ? inflight - IW'(1) : inflight;
      err <= err | (res_hs && !pop && inflight == 0);
      bus.res_valid <= res_hs;
      if (res_hs) bus.res_data <= bus.s_axis_result_tdata;
      state <= (state == IDLE)  ? ((start && count != 0) ? ISSUE : IDLE) :
               (state == ISSUE) ? ((batch == 0) ? DRAIN : ISSUE) :
               (state == DRAIN) ? ((inflight == 0) ? DONE : DRAIN) : IDLE;
    end
  end
endmodule
